// File: rtl/id_pipeline_controller.sv
// Decode-stage sequencer for the 5-stage RV32I core.
// It owns the IF/ID instruction register and the ID/EX control shadow
// (rd, write enable, load flag). It stalls on load-use hazards, squashes
// wrong-path fetch beats after a taken branch or jump, and honours EX
// back-pressure.
// Optional: define HAZ_PERF_EN to add saturating stall and flush event counters.
module id_pipeline_controller #(
  parameter int              XLEN      = 32,
  parameter int              REG_W     = 5,
  parameter int              FLUSH_LAT = 1,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  if_instr,
  output logic             if_ready,
  output logic [XLEN-1:0]  id_instr,
  output logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             ex_ready,
  input  logic             ex_taken,
  output logic             ex_valid,
  output logic [REG_W-1:0] ex_rd,
  output logic             ex_we,
  output logic             ex_is_load,
  output logic             id_ex_en,
  output logic             stall,
  output logic             flush
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [2:0] DROP_INIT = 3'(FLUSH_LAT);

  state_t     state, state_nxt;
  logic [2:0] drop_cnt, drop_nxt;

  logic taken_q;
  logic hit_rs1, hit_rs2;
  logic load_use;

  // A redirect only counts when a live instruction actually leaves EX.
  assign taken_q  = ex_taken & ex_valid & ex_ready;
  assign hit_rs1  = id_use_rs1 & (id_rs1 == ex_rd);
  assign hit_rs2  = id_use_rs2 & (id_rs2 == ex_rd);
  // x0 is never a real producer, so a load to x0 cannot cause a hazard.
  assign load_use = id_valid & ex_valid & ex_is_load & (ex_rd != '0) & (hit_rs1 | hit_rs2);

  // State register and drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  // Next state: a redirect arms the discard window. Each accepted beat
  // during the window uses up one slot.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    if (taken_q) begin
      if (FLUSH_LAT > 0) begin
        state_nxt = FLUSH;
        drop_nxt  = DROP_INIT;
      end else begin
        state_nxt = RUN;
        drop_nxt  = '0;
      end
    end else if (state == FLUSH && if_valid) begin
      drop_nxt = (drop_cnt == '0) ? '0 : drop_cnt - 3'd1;
      if (drop_cnt <= 3'd1) state_nxt = RUN;
    end
  end

  // Handshake and control outputs, all forced low while reset is asserted.
  // Priority order: redirect, then discard window, then back-pressure,
  // then hazard, then normal flow.
  always_comb begin
    if_ready = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    id_ex_en = 1'b0;
    if (rst_n) begin
      if (taken_q || state == FLUSH) begin
        flush    = 1'b1;
        if_ready = 1'b1;
        id_ex_en = 1'b1;
      end else if (!ex_ready) begin
        // Hold everything. The hazard is re-evaluated once EX frees up.
      end else if (load_use) begin
        stall    = 1'b1;
        id_ex_en = 1'b1;
      end else begin
        if_ready = 1'b1;
        id_ex_en = 1'b1;
      end
    end
  end

  // IF/ID register: a redirect loads NOP. Normal flow captures the fetch beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (taken_q) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else if (state == RUN && ex_ready && !load_use) begin
      if (if_valid) begin
        id_instr <= if_instr;
        id_valid <= 1'b1;
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

  // ID/EX control shadow. On normal flow it copies ID, with fields gated by
  // id_valid. Redirects, discards and stalls load a bubble. Back-pressure holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rd      <= '0;
      ex_we      <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (id_ex_en) begin
      if (if_ready && !flush) begin
        ex_valid   <= id_valid;
        ex_rd      <= id_valid ? id_rd : '0;
        ex_we      <= id_valid & id_we;
        ex_is_load <= id_valid & id_is_load;
      end else begin
        ex_valid   <= 1'b0;
        ex_rd      <= '0;
        ex_we      <= 1'b0;
        ex_is_load <= 1'b0;
      end
    end
  end

`ifdef HAZ_PERF_EN
  // Saturating event counters for stall cycles and accepted redirects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && perf_stall_cnt != 32'hFFFF_FFFF)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (taken_q && perf_flush_cnt != 32'hFFFF_FFFF)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_pipeline_controller.md
Name: id_pipeline_controller

Overview:
- Sequences the decode stage of the 5-stage RV32I core.
- Owns the IF/ID instruction register feeding the instruction decoder and the ID/EX control shadow (rd, write-enable, load flag).
- Resolves load-use hazards by stalling ID and injecting a bubble into EX.
- Squashes wrong-path instructions on a taken branch/jump and honours EX back-pressure.

Parameters:
- XLEN, 32, instruction width.
- REG_W, 5, register-address width ($clog2(XLEN)).
- FLUSH_LAT, 1, number of extra fetch beats discarded after a redirect (range 0–7).
- NOP_INSTR, 32'h00000013, value loaded into the IF/ID register on reset/flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  XLEN  fetched instruction.
- if_ready  out  1  controller accepts (or discards) the fetch beat this cycle.
- id_instr  out  XLEN  IF/ID register, drives the decoder.
- id_valid  out  1  id_instr is a live instruction.
- id_rs1, id_rs2  in  REG_W each  decoder A_select / B_select for id_instr.
- id_use_rs1, id_use_rs2  in  1 each  the instruction actually reads rs1/rs2.
- id_rd  in  REG_W  decoder D_addr.
- id_we  in  1  decoder register write enable.
- id_is_load  in  1  decoder MD (load).
- ex_ready  in  1  EX stage can accept a new instruction.
- ex_taken  in  1  EX resolved a taken branch/jump (redirect issued to fetch the same cycle).
- ex_valid  out  1  ID/EX register holds a live instruction.
- ex_rd  out  REG_W  ID/EX destination register.
- ex_we  out  1  ID/EX write enable (forced 0 when ex_valid=0).
- ex_is_load  out  1  ID/EX load flag (forced 0 when ex_valid=0).
- id_ex_en  out  1  load enable for the remaining ID/EX datapath registers.
- stall  out  1  load-use stall this cycle.
- flush  out  1  squash active this cycle.

Behaviour:
- Reset (rst_n=0 at clk edge): state=RUN, id_instr=NOP_INSTR, id_valid=0, ex_valid=0, ex_rd=0, ex_we=0, ex_is_load=0, drop counter=0. Combinational outputs under reset: if_ready=0, stall=0, flush=0, id_ex_en=0.
- taken_q = ex_taken & ex_valid & ex_ready. ex_taken is ignored otherwise.
- load_use = id_valid & ex_valid & ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- FSM states RUN, FLUSH. Priority: reset > taken_q > ~ex_ready > load_use > normal.
- taken_q (any state):
  - flush=1, if_ready=1 and the beat is discarded.
  - Next id_valid=0, id_instr=NOP_INSTR, ex_valid=0; id_ex_en=1.
  - If FLUSH_LAT>0: go to FLUSH with counter=FLUSH_LAT. Otherwise stay in RUN.
- FLUSH:
  - if_ready=1, flush=1; each accepted beat (if_valid=1) is discarded and decrements the counter.
  - At 0, go to RUN; the next beat is live.
  - ID/EX advances bubbles (ex_valid=0). Back-pressure does not pause discards.
- ~ex_ready (RUN): everything holds, if_ready=0, id_ex_en=0, stall=0.
- load_use (RUN, ex_ready=1):
  - stall=1, if_ready=0; IF/ID holds.
  - ID/EX takes a bubble: ex_valid=0, ex_we=0, ex_is_load=0; id_ex_en=1.
  - Exactly one bubble per load-use pair, because the next cycle ex_is_load=0.
- Normal (RUN): if_ready=1, id_ex_en=1.
  - ex_valid<=id_valid; ex_rd/ex_we/ex_is_load<=id_* gated by id_valid.
  - IF/ID: if if_valid, id_instr<=if_instr and id_valid<=1; else id_valid<=0 and id_instr holds.
- rd=x0 never triggers load_use.
- All registered outputs change only on clk; latency IF->ID is 1 cycle and ID->EX is 1 cycle.

Optional Feature:
- HAZ_PERF_EN defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cnt increments on each stall=1 cycle.
  - perf_flush_cnt increments on each taken_q.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: ports and counters are absent; no other behaviour change.

Test Plan:
- Reset: hold rst_n=0 3 cycles with if_valid=1 -> id_valid=0, id_instr=32'h00000013, ex_valid=0, if_ready=0; release -> first instr in id_instr 1 cycle later.
- Load-use: EX holds lw x5 (ex_is_load=1, ex_rd=5), ID holds add x6,x5,x7 (id_use_rs1=1, id_rs1=5) -> stall=1 for exactly 1 cycle, ex_valid=0 next, add enters EX the cycle after.
- x0 exemption: ex_rd=0, ex_is_load=1, id_rs1=0 -> stall=0, normal advance.
- Flush FLUSH_LAT=1: ex_taken=1 -> flush=1 for 2 accepted beats, both discarded, id_valid=0 throughout; third beat captured live.
- Back-pressure with hazard: ex_ready=0 for 4 cycles during a load_use condition -> all state holds, stall=0, if_ready=0; ex_ready=1 -> stall=1 one cycle, then resume.
- Reset mid-FLUSH: assert rst_n=0 while counter=1 -> RUN, counter=0, all outputs at reset values next edge; with HAZ_PERF_EN, counters read 0.
